icache_sa: RTL and testbench
============================

// Module: icache_sa
// PURPOSE
//  Parametrised N-way set-associative, read-only instruction cache between IFU and an AXI4 read master port.
//  Successor to the direct-mapped icache: configurable ways/sets/line size, valid/ready request+response
//  handshake, correct burst length, round-robin replacement, bus-error reporting and fence.i invalidation.
// PARAMETERS
//  WAYS        2    associativity, power of 2, 1..8
//  SETS        32   sets per way, power of 2, >=2
//  LINE_BYTES  64   line size in bytes, power of 2, 16..128
//  ADDR_W      32   address width
//  DATA_W      64   fetch/bus word width (fixed 64 in this generation)
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       asynchronous reset, active low
//  req_valid  in   1       fetch request
//  req_ready  out  1       cache accepts request (IDLE only)
//  req_addr   in   ADDR_W  fetch address, byte granular; [2:0] ignored
//  rsp_valid  out  1       response valid, held until rsp_ready
//  rsp_ready  in   1       IFU accepts response
//  rsp_data   out  DATA_W  8-byte-aligned word containing req_addr
//  rsp_err    out  1       refill got non-OKAY rresp; rsp_data undefined
//  fence_i    in   1       single-cycle pulse: invalidate all lines
//  araddr out ADDR_W; arvalid out 1; arready in 1; arlen out 8; arsize out 3; arburst out 2
//  rdata in DATA_W; rresp in 2; rvalid in 1; rlast in 1; rready out 1   (AXI4 read channels)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, all valid bits=0, RR pointers=0, req_ready=0 while in reset then 1,
//   rsp_valid=0, rsp_err=0, arvalid=0, rready=0. Reset mid-refill abandons burst; no line becomes valid.
//  Address split: offset=log2(LINE_BYTES), index=log2(SETS), tag=remaining upper bits.
//  FSM: IDLE -> LOOKUP on req_valid&req_ready (req_addr registered).
//   LOOKUP: compare tag against all ways of set; hit -> RESP; miss -> MISS_AR (victim chosen here).
//   MISS_AR: arvalid=1, araddr=line-aligned addr, arlen=LINE_BYTES/8-1, arsize=3, arburst=INCR;
//     araddr/arvalid stable until arready; -> MISS_R on arvalid&arready.
//   MISS_R: rready=1; each rvalid beat writes victim way word[beat], beat counter wraps at LINE_BYTES/8;
//     beat==req word offset captures rdata into response register. On rlast beat -> RESP;
//     tag+valid written only if no beat carried rresp!=OKAY, else rsp_err=1 and line stays invalid.
//   RESP: rsp_valid=1; -> IDLE on rsp_ready. rsp_err cleared on leaving RESP.
//  Latency: hit -> rsp_valid 2 cycles after accept; miss -> 1 cycle after rlast beat.
//  Hit data read from way array, selected by one-hot hit vector; >1 way hit is illegal (assertion).
//  Victim: lowest-numbered invalid way in set; if all valid, per-set RR pointer way, pointer += 1 (wraps).
//  fence_i: in IDLE/LOOKUP/RESP clears all valid bits next edge (a LOOKUP in that cycle uses pre-clear
//   state). During MISS_AR/MISS_R: latched pending, refilled line NOT validated, clear on entering RESP.
//  fence_i with req_valid same cycle in IDLE: fence wins, req_ready=0 that cycle.
//  rlast before expected beat count or extra beats: treated as end of burst; assertion flags mismatch.
// STRUCTURE
//  icache_pkg: FSM state enum, AXI constants (BURST_INCR=2'b01, SIZE_8B=3'd3, RESP_OKAY=2'b00),
//   localparam helpers for OFFSET_W/INDEX_W/TAG_W/BEATS.
//  Sub-module icache_way (xWAYS): valid+tag+data storage for one way, async read at index,
//   one-word write port and tag/valid write, global valid clear. Top holds FSM, RR pointers, AXI logic.
// TESTING
//  Cold miss 0x8000_0008 with OKAY burst words 0x1000+i -> arlen=7, araddr=0x8000_0000, rsp_data=0x1001.
//  Re-fetch 0x8000_0030 -> no arvalid, rsp_valid 2 cycles after accept, rsp_data=0x1006.
//  Three tags same set (0x8000_0000,0x8000_0800,0x8000_1000), WAYS=2 -> third evicts way0; refetch 0x8000_0000 misses.
//  Burst beat 3 rresp=SLVERR -> rsp_err=1; refetch same address misses again.
//  fence_i during MISS_R -> response delivered, subsequent fetch of that line and of prior hits all miss.
//  rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_data stable; rst_n pulse mid-burst -> arvalid/rready=0, all miss.

Source files
------------

// File: rtl/icache_sa_pkg.sv
// Shared types and constants for the set-associative instruction cache.
// Geometry helpers derive field widths from the cache parameters.
package icache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_AR,
        S_MISS_R,
        S_RESP
    } state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_8B    = 3'd3;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    function automatic int offset_w(int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int index_w(int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(int addr_w, int line_bytes, int sets);
        return addr_w - $clog2(line_bytes) - $clog2(sets);
    endfunction

    function automatic int beats(int line_bytes);
        return line_bytes / 8;
    endfunction

    function automatic int way_w(int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/icache_sa_if.sv
// Fetch-side request/response handshake and AXI4 read channels.
// The cache is the slave of the fetch bundle and the master of the AXI bundle.
interface icache_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );
    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

interface icache_axi_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rlast;
    logic              rready;

    modport master (
        output araddr, arvalid, arlen, arsize, arburst, rready,
        input  arready, rdata, rresp, rvalid, rlast
    );
    modport slave (
        input  araddr, arvalid, arlen, arsize, arburst, rready,
        output arready, rdata, rresp, rvalid, rlast
    );
endinterface

// File: rtl/icache_sa_way.sv
// One cache way: valid bits, tags and line data for every set.
// Reads are asynchronous; valid bits clear globally for fence.i.
module icache_way #(
    parameter int  SETS   = 32,
    parameter int  BEATS  = 8,
    parameter int  TAG_W  = 21,
    parameter int  DATA_W = 64,
    localparam int IDX_W  = $clog2(SETS),
    localparam int BW     = $clog2(BEATS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  rd_idx_i,
    input  logic [BW-1:0]     rd_word_i,
    output logic              rd_valid_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic              wr_en_i,
    input  logic [BW-1:0]     wr_word_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              tag_we_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic              wr_valid_i,
    input  logic              clr_i
);
    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q [SETS];
    logic [DATA_W-1:0] mem_q [SETS*BEATS];

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = mem_q[{rd_idx_i, rd_word_i}];

    // Valid bits: global clear has priority over a per-set update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (clr_i) begin
            valid_q <= '0;
        end else if (tag_we_i) begin
            valid_q[wr_idx_i] <= wr_valid_i;
        end
    end

    // Tag and data arrays need no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (tag_we_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
        end
        if (wr_en_i) begin
            mem_q[{wr_idx_i, wr_word_i}] <= wr_data_i;
        end
    end
endmodule

// File: rtl/icache_sa.sv
// N-way set-associative read-only instruction cache with AXI4 refill.
// Blocking: one fetch in flight, round-robin replacement per set.
module icache_sa
    import icache_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 32,
    parameter int LINE_BYTES = 64,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64
) (
    input logic            clk,
    input logic            rst_n,
    input logic            fence_i,
    icache_fetch_if.slave  fetch,
    icache_axi_if.master   axi
);
    localparam int OFF_W  = offset_w(LINE_BYTES);
    localparam int IDX_W  = index_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_W, LINE_BYTES, SETS);
    localparam int BEATS  = beats(LINE_BYTES);
    localparam int BEAT_W = $clog2(BEATS);
    localparam int WAY_W  = way_w(WAYS);
    localparam int AQ_W   = ADDR_W - 3;

    state_e state_q, state_d;

    logic [AQ_W-1:0]   addr_q;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic [WAY_W-1:0]  rr_q [SETS];
    logic [BEAT_W-1:0] beat_q;
    logic              err_q, fpend_q, rsp_err_q;
    logic [DATA_W-1:0] rsp_data_q;

    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [BEAT_W-1:0] word;

    logic [WAYS-1:0]   way_valid, hit;
    logic [TAG_W-1:0]  way_tag  [WAYS];
    logic [DATA_W-1:0] way_data [WAYS];
    logic [DATA_W-1:0] hit_data;

    logic accept, beat_fire, last_fire, beat_err, fence_now;
    logic tag_we, wr_valid, clr;

    assign tag  = addr_q[AQ_W-1 -: TAG_W];
    assign idx  = addr_q[OFF_W-3 +: IDX_W];
    assign word = addr_q[0 +: BEAT_W];

    assign accept    = fetch.req_valid && state_q == S_IDLE && !fence_i;
    assign beat_fire = state_q == S_MISS_R && axi.rvalid;
    assign last_fire = beat_fire && axi.rlast;
    assign beat_err  = axi.rresp != RESP_OKAY;
    assign fence_now = fence_i || fpend_q;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way #(
            .SETS   (SETS),
            .BEATS  (BEATS),
            .TAG_W  (TAG_W),
            .DATA_W (DATA_W)
        ) u_way (
            .clk        (clk),
            .rst_n      (rst_n),
            .rd_idx_i   (idx),
            .rd_word_i  (word),
            .rd_valid_o (way_valid[w]),
            .rd_tag_o   (way_tag[w]),
            .rd_data_o  (way_data[w]),
            .wr_idx_i   (idx),
            .wr_en_i    (beat_fire && victim_q == WAY_W'(w)),
            .wr_word_i  (beat_q),
            .wr_data_i  (axi.rdata),
            .tag_we_i   (tag_we && victim_q == WAY_W'(w)),
            .wr_tag_i   (tag),
            .wr_valid_i (wr_valid),
            .clr_i      (clr)
        );
        assign hit[w] = way_valid[w] && way_tag[w] == tag;
    end

    // Hit data and victim choice: lowest invalid way, else the RR way.
    always_comb begin
        hit_data = '0;
        victim_d = rr_q[idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_data = hit_data | ({DATA_W{hit[w]}} & way_data[w]);
            if (!way_valid[w]) victim_d = WAY_W'(w);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (accept) state_d = S_LOOKUP;
            S_LOOKUP:  state_d = (|hit) ? S_RESP : S_MISS_AR;
            S_MISS_AR: if (axi.arready) state_d = S_MISS_R;
            S_MISS_R:  if (last_fire) state_d = S_RESP;
            S_RESP:    if (fetch.rsp_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs; the victim is invalidated while its refill is requested.
    always_comb begin
        fetch.req_ready = rst_n && state_q == S_IDLE && !fence_i;
        fetch.rsp_valid = state_q == S_RESP;
        fetch.rsp_data  = rsp_data_q;
        fetch.rsp_err   = rsp_err_q;
        axi.arvalid     = state_q == S_MISS_AR;
        axi.araddr      = {tag, idx, {OFF_W{1'b0}}};
        axi.arlen       = 8'(BEATS - 1);
        axi.arsize      = SIZE_8B;
        axi.arburst     = BURST_INCR;
        axi.rready      = state_q == S_MISS_R;
        tag_we   = state_q == S_MISS_AR || last_fire;
        wr_valid = last_fire && !err_q && !beat_err && !fence_now;
        clr      = (fence_i && (state_q == S_IDLE || state_q == S_LOOKUP ||
                                state_q == S_RESP)) ||
                   (last_fire && fence_now);
    end

    // Request, refill bookkeeping and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            victim_q   <= '0;
            beat_q     <= '0;
            err_q      <= 1'b0;
            fpend_q    <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            if (accept) addr_q <= fetch.req_addr[ADDR_W-1:3];
            if (state_q == S_LOOKUP) begin
                victim_q <= victim_d;
                if (|hit) begin
                    rsp_data_q <= hit_data;
                    rsp_err_q  <= 1'b0;
                end
            end
            if (state_q == S_MISS_AR) begin
                beat_q <= '0;
                err_q  <= 1'b0;
            end
            if ((state_q == S_MISS_AR || state_q == S_MISS_R) && fence_i) begin
                fpend_q <= 1'b1;
            end
            if (beat_fire) begin
                beat_q <= beat_q + BEAT_W'(1);
                err_q  <= err_q || beat_err;
                if (beat_q == word) rsp_data_q <= axi.rdata;
            end
            if (last_fire) begin
                fpend_q   <= 1'b0;
                rsp_err_q <= err_q || beat_err;
            end
            if (state_q == S_RESP && fetch.rsp_ready) rsp_err_q <= 1'b0;
        end
    end

    // Round-robin pointer advances only when a full set is replaced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else if (state_q == S_LOOKUP && !(|hit) && (&way_valid)) begin
            rr_q[idx] <= (rr_q[idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[idx] + WAY_W'(1);
        end
    end

    a_onehot_hit: assert property (@(posedge clk) disable iff (!rst_n)
        state_q == S_LOOKUP |-> $onehot0(hit));

    a_burst_len: assert property (@(posedge clk) disable iff (!rst_n)
        beat_fire |-> (axi.rlast == (beat_q == BEAT_W'(BEATS - 1))));
endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa with a set-associative reference model.
// Memory word at address A is epoch<<32 | 0x1000 + (A-0x8000_0000)/8.
module tb_icache_sa;
    localparam int W = 2;
    localparam int S = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fence = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        rsp_ready = 1'b0;
    logic        arready = 1'b0;
    logic [63:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rvalid = 1'b0;
    logic        rlast = 1'b0;

    icache_fetch_if #(.ADDR_W(32), .DATA_W(64)) fif ();
    icache_axi_if   #(.ADDR_W(32), .DATA_W(64)) aif ();

    assign fif.req_valid = req_valid;
    assign fif.req_addr  = req_addr;
    assign fif.rsp_ready = rsp_ready;
    assign aif.arready   = arready;
    assign aif.rdata     = rdata;
    assign aif.rresp     = rresp;
    assign aif.rvalid    = rvalid;
    assign aif.rlast     = rlast;

    icache_sa #(
        .WAYS(W), .SETS(S), .LINE_BYTES(64), .ADDR_W(32), .DATA_W(64)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .fence_i (fence),
        .fetch   (fif),
        .axi     (aif)
    );

    int n_vec = 0;
    int n_fail = 0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    // Reference model state
    bit          m_valid [S][W];
    int unsigned m_tag   [S][W];
    int unsigned m_ep    [S][W];
    int          m_rr    [S];
    int unsigned ep = 0;

    logic [63:0] exp_data = '0;
    logic        exp_err = 1'b0;
    logic [31:0] cur_line = '0;
    logic        mon_en = 1'b0;

    function automatic logic [63:0] memval(input logic [31:0] a, input int unsigned e);
        return {e, 32'h0} + 64'h1000 + 64'((a - 32'h8000_0000) >> 3);
    endfunction

    function automatic void model_clear(input bit rr_too);
        for (int s = 0; s < S; s++) begin
            for (int w = 0; w < W; w++) m_valid[s][w] = 0;
            if (rr_too) m_rr[s] = 0;
        end
        ep++;
    endfunction

    // Compare process: AR fields and response contents on every cycle shown.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (aif.arvalid) begin
                check("araddr", aif.araddr, cur_line);
                check("arlen", aif.arlen, 8'd7);
                check("arsize", aif.arsize, 3'd3);
                check("arburst", aif.arburst, 2'b01);
            end
            if (fif.rsp_valid) begin
                check("rsp_err", fif.rsp_err, exp_err);
                if (!exp_err) check("rsp_data", fif.rsp_data, exp_data);
            end
        end
    end

    logic        last_ar;
    logic [31:0] last_araddr;
    logic [63:0] last_data;

    task automatic fetch(input logic [31:0] a, input int err_beat,
                         input int fence_beat, input int hold);
        int s, hitw, v, lat, n;
        bit miss, done;
        int unsigned t;
        logic [63:0] d0;
        s = int'((a >> 6) & 32'd31);
        t = a >> 11;
        hitw = -1;
        for (int w = 0; w < W; w++)
            if (m_valid[s][w] && m_tag[s][w] == t) hitw = w;
        miss = hitw < 0;
        exp_data = miss ? memval(a, ep) : memval(a, m_ep[s][hitw]);
        exp_err = miss && err_beat >= 0;
        cur_line = a & ~32'd63;
        if (miss) begin
            v = -1;
            for (int w = W - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
            if (v < 0) begin
                v = m_rr[s];
                m_rr[s] = (m_rr[s] + 1) % W;
            end
            m_valid[s][v] = (err_beat < 0) && (fence_beat < 0);
            m_tag[s][v] = t;
            m_ep[s][v] = ep;
        end
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_addr = a;
        n = 0;
        @(negedge clk);
        while (!fif.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready", fif.req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        done = 0;
        last_ar = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            lat++;
            if (fif.rsp_valid) begin
                done = 1;
            end else if (aif.arvalid && !last_ar) begin
                last_ar = 1'b1;
                last_araddr = aif.araddr;
                arready = 1'b1;
                @(posedge clk); #1;
                arready = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    rvalid = 1'b1;
                    rdata = memval(cur_line + 32'(8 * i), ep);
                    rresp = (i == err_beat) ? 2'b10 : 2'b00;
                    rlast = (i == 7);
                    fence = (i == fence_beat);
                    @(negedge clk);
                    check("rready", aif.rready, 1'b1);
                    @(posedge clk); #1;
                end
                rvalid = 1'b0;
                rlast = 1'b0;
                rresp = 2'b00;
                fence = 1'b0;
                @(negedge clk);
                check("miss_lat", fif.rsp_valid, 1'b1);
                done = fif.rsp_valid;
            end
        end
        check("rsp_seen", done, 1'b1);
        check("hit_miss", last_ar, miss);
        if (!miss) check("hit_lat", lat, 2);
        last_data = fif.rsp_data;
        if (done) begin
            d0 = fif.rsp_data;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("hold_valid", fif.rsp_valid, 1'b1);
                check("hold_data", fif.rsp_data, d0);
            end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            @(negedge clk);
            check("rsp_drop", fif.rsp_valid, 1'b0);
            check("err_clear", fif.rsp_err, 1'b0);
        end
        if (fence_beat >= 0) model_clear(0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int s = 0; s < S; s++) m_rr[s] = 0;
        #12;
        check("rst_req_ready", fif.req_ready, 1'b0);
        check("rst_rsp_valid", fif.rsp_valid, 1'b0);
        check("rst_rsp_err", fif.rsp_err, 1'b0);
        check("rst_arvalid", aif.arvalid, 1'b0);
        check("rst_rready", aif.rready, 1'b0);
        #10 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", fif.req_ready, 1'b1);
        mon_en = 1'b1;

        fetch(32'h8000_0008, -1, -1, 0);
        check("lit_cold_data", last_data, 64'h1001);
        check("lit_cold_araddr", last_araddr, 32'h8000_0000);
        fetch(32'h8000_0030, -1, -1, 0);
        check("lit_hit_data", last_data, 64'h1006);
        check("lit_hit_noar", last_ar, 1'b0);

        fetch(32'h8000_0800, -1, -1, 0);
        fetch(32'h8000_1000, -1, -1, 0);
        fetch(32'h8000_0000, -1, -1, 0);
        check("lit_evict_miss", last_ar, 1'b1);
        fetch(32'h8000_1008, -1, -1, 0);
        check("lit_keep_hit", last_data, 64'h1201);

        fetch(32'h8000_2040, 3, -1, 0);
        fetch(32'h8000_2040, -1, -1, 0);
        check("lit_err_refetch", last_ar, 1'b1);

        fetch(32'h8000_3000, -1, 4, 0);
        fetch(32'h8000_3000, -1, -1, 0);
        fetch(32'h8000_1008, -1, -1, 0);
        check("lit_fence_miss", last_ar, 1'b1);

        @(posedge clk); #1;
        fence = 1'b1;
        req_valid = 1'b1;
        req_addr = 32'h8000_3000;
        @(negedge clk);
        check("fence_blocks_req", fif.req_ready, 1'b0);
        @(posedge clk); #1;
        fence = 1'b0;
        req_valid = 1'b0;
        model_clear(0);

        fetch(32'h8000_3000, -1, -1, 0);
        fetch(32'h8000_3010, -1, -1, 5);

        cur_line = 32'h8000_0000;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_addr = 32'h8000_0000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!aif.arvalid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("rstb_arvalid", aif.arvalid, 1'b1);
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rvalid = 1'b1;
            rdata = memval(cur_line + 32'(8 * i), ep);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        rvalid = 1'b0;
        #1;
        check("rstb_arvalid0", aif.arvalid, 1'b0);
        check("rstb_rready0", aif.rready, 1'b0);
        check("rstb_rsp_valid0", fif.rsp_valid, 1'b0);
        check("rstb_req_ready0", fif.req_ready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear(1);

        fetch(32'h8000_0000, -1, -1, 0);
        check("lit_rst_miss", last_ar, 1'b1);
        fetch(32'h8000_3010, -1, -1, 0);
        check("lit_rst_miss2", last_ar, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
